// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: op codes, FSM states and default widths.
// Defining MEM_STAGE_INDIRECT_EN adds the IND state used by LDI/STI.
package mem_stage_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefCtrlW = 32;

`ifdef MEM_STAGE_INDIRECT_EN
    localparam bit IndirectEn = 1'b1;
`else
    localparam bit IndirectEn = 1'b0;
`endif

    typedef enum logic [2:0] {NONE, LDR, LDB, STR, STB, LDI, STI} mem_op_t;

`ifdef MEM_STAGE_INDIRECT_EN
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, IND} mem_state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
`endif

    function automatic logic isStore(input mem_op_t op);
        return op inside {STR, STB, STI};
    endfunction

    function automatic logic isByteOp(input mem_op_t op);
        return op inside {LDB, STB};
    endfunction

    // Without the indirect option LDI/STI collapse to plain word accesses.
    function automatic logic isIndirect(input mem_op_t op);
        return IndirectEn && (op inside {LDI, STI});
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane logic: address alignment, byte mask, store-data
// replication and zero-extended byte extraction for loads.
module mem_byte_lane #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         wrByte,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  rdLane,
    input  logic                         rdByte,
    output logic [DATA_W-1:0]            alignAddr,
    output logic [DATA_W/8-1:0]          laneMask,
    output logic [DATA_W-1:0]            laneWdata,
    output logic [DATA_W-1:0]            loadData
);

    localparam int unsigned Lanes    = DATA_W / 8;
    localparam int unsigned LaneBits = $clog2(Lanes);

    logic [LaneBits-1:0] wrLane;
    logic [DATA_W-1:0]   rdShifted;

    assign wrLane    = addr[LaneBits-1:0];
    assign alignAddr = {addr[DATA_W-1:LaneBits], {LaneBits{1'b0}}};
    assign rdShifted = rdata >> {rdLane, 3'b000};

    always_comb begin
        laneMask  = '1;
        laneWdata = wdata;
        if (wrByte) begin
            laneMask  = {{(Lanes-1){1'b0}}, 1'b1} << wrLane;
            laneWdata = {Lanes{wdata[7:0]}};
        end
    end

    always_comb begin
        loadData = rdata;
        if (rdByte) begin
            loadData = {{(DATA_W-8){1'b0}}, rdShifted[7:0]};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one load/store per instruction and holds
// upstream until the memory responds. Option: MEM_STAGE_INDIRECT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CTRL_W = DefCtrlW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  mem_op_t             in_op,
    input  logic [DATA_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [DATA_W-1:0]   in_alu,
    input  logic [DATA_W-1:0]   in_ir,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic                stall_in,
    output logic                stall_out,
    output logic [DATA_W-1:0]   mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_mdr,
    output logic [DATA_W-1:0]   out_alu,
    output logic [DATA_W-1:0]   out_ir,
    output logic [DATA_W-1:0]   out_pc,
    output logic [CTRL_W-1:0]   out_ctrl
);

    localparam int unsigned Lanes    = DATA_W / 8;
    localparam int unsigned LaneBits = $clog2(Lanes);

    mem_state_t          stateQ, stateD;
    mem_op_t             opQ;
    logic [LaneBits-1:0] laneQ;
    logic [DATA_W-1:0]   memAddrQ, memWdataQ, mdrQ, aluQ, irQ, pcQ;
    logic [Lanes-1:0]    memWmaskQ;
    logic [CTRL_W-1:0]   ctrlQ;

    logic [DATA_W-1:0]   alignAddr, laneWdata, loadData, rdResult;
    logic [Lanes-1:0]    laneMask;
    logic                takeIn, accept, passThrough, memDone;
    logic                commitEn;
    logic [DATA_W-1:0]   commitMdr, commitAlu, commitIr, commitPc;
    logic [CTRL_W-1:0]   commitCtrl;

    mem_byte_lane #(
        .DATA_W(DATA_W)
    ) byteLane (
        .addr      (in_addr),
        .wdata     (in_wdata),
        .wrByte    (isByteOp(in_op)),
        .rdata     (mem_rdata),
        .rdLane    (laneQ),
        .rdByte    (opQ == LDB),
        .alignAddr (alignAddr),
        .laneMask  (laneMask),
        .laneWdata (laneWdata),
        .loadData  (loadData)
    );

    assign takeIn      = (stateQ == IDLE) && in_valid && !stall_in;
    assign accept      = takeIn && (in_op != NONE);
    assign passThrough = takeIn && (in_op == NONE);
    assign rdResult    = isStore(opQ) ? '0 : loadData;

    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;
    assign mem_wmask = memWmaskQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        memDone = 1'b0;
        case (stateQ)
            IDLE: if (accept) stateD = ACCESS;
            ACCESS: begin
                if (mem_resp) begin
`ifdef MEM_STAGE_INDIRECT_EN
                    if (isIndirect(opQ)) begin
                        stateD = IND;
                    end else begin
                        memDone = 1'b1;
                        stateD  = stall_in ? DONE : IDLE;
                    end
`else
                    memDone = 1'b1;
                    stateD  = stall_in ? DONE : IDLE;
`endif
                end
            end
`ifdef MEM_STAGE_INDIRECT_EN
            IND: begin
                if (mem_resp) begin
                    memDone = 1'b1;
                    stateD  = stall_in ? DONE : IDLE;
                end
            end
`endif
            DONE: if (!stall_in) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall_out = 1'b0;
        case (stateQ)
            IDLE: stall_out = accept;
            ACCESS: begin
                // The first leg of an indirect op is always a pointer read.
                mem_read  = !isStore(opQ) || isIndirect(opQ);
                mem_write = !mem_read;
                stall_out = !mem_resp || isIndirect(opQ);
            end
`ifdef MEM_STAGE_INDIRECT_EN
            IND: begin
                mem_read  = (opQ == LDI);
                mem_write = (opQ == STI);
                stall_out = !mem_resp;
            end
`endif
            DONE: stall_out = stall_in;
            default: stall_out = 1'b0;
        endcase
        if (!rst_n) stall_out = 1'b0;
    end

    always_comb begin
        commitEn   = 1'b0;
        commitMdr  = rdResult;
        commitAlu  = aluQ;
        commitIr   = irQ;
        commitPc   = pcQ;
        commitCtrl = ctrlQ;
        if (passThrough) begin
            commitEn   = 1'b1;
            commitMdr  = '0;
            commitAlu  = in_alu;
            commitIr   = in_ir;
            commitPc   = in_pc;
            commitCtrl = in_ctrl;
        end else if (memDone && !stall_in) begin
            commitEn = 1'b1;
        end else if ((stateQ == DONE) && !stall_in) begin
            commitEn  = 1'b1;
            commitMdr = mdrQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opQ       <= NONE;
            laneQ     <= '0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            memWmaskQ <= '0;
            mdrQ      <= '0;
            aluQ      <= '0;
            irQ       <= '0;
            pcQ       <= '0;
            ctrlQ     <= '0;
            out_valid <= 1'b0;
            out_mdr   <= '0;
            out_alu   <= '0;
            out_ir    <= '0;
            out_pc    <= '0;
            out_ctrl  <= '0;
        end else begin
            if (accept) begin
                opQ       <= in_op;
                laneQ     <= in_addr[LaneBits-1:0];
                memAddrQ  <= alignAddr;
                memWdataQ <= laneWdata;
                memWmaskQ <= laneMask;
                aluQ      <= in_alu;
                irQ       <= in_ir;
                pcQ       <= in_pc;
                ctrlQ     <= in_ctrl;
            end
`ifdef MEM_STAGE_INDIRECT_EN
            if ((stateQ == ACCESS) && mem_resp && isIndirect(opQ)) begin
                memAddrQ  <= {mem_rdata[DATA_W-1:LaneBits], {LaneBits{1'b0}}};
                memWmaskQ <= '1;
            end
`endif
            if (memDone && stall_in) mdrQ <= rdResult;
            if (!stall_in) begin
                out_valid <= commitEn;
                if (commitEn) begin
                    out_mdr  <= commitMdr;
                    out_alu  <= commitAlu;
                    out_ir   <= commitIr;
                    out_pc   <= commitPc;
                    out_ctrl <= commitCtrl;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// stall/reset/indirect sequences, and a randomized run against a reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    mem_op_t     in_op;
    logic [15:0] in_addr, in_wdata, in_alu, in_ir, in_pc;
    logic [31:0] in_ctrl;
    logic        stall_in, stall_out;
    logic [15:0] mem_addr;
    logic        mem_read, mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_resp;
    logic        out_valid;
    logic [15:0] out_mdr, out_alu, out_ir, out_pc;
    logic [31:0] out_ctrl;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .DATA_W(16),
        .CTRL_W(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_alu    (in_alu),
        .in_ir     (in_ir),
        .in_pc     (in_pc),
        .in_ctrl   (in_ctrl),
        .stall_in  (stall_in),
        .stall_out (stall_out),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .out_valid (out_valid),
        .out_mdr   (out_mdr),
        .out_alu   (out_alu),
        .out_ir    (out_ir),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        mem_op_t     op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] alu;
        logic [15:0] rdata;
        int          lat;
        logic [15:0] expAddr;
        logic [1:0]  expMask;
        logic [15:0] expWdata;
        logic        expWrite;
        logic [15:0] expMdr;
    } vec_t;

    vec_t vecs[$];

    // One full transaction with stall_in low; lat = wait cycles before mem_resp.
    task automatic runVec(input vec_t v, input int idx);
        logic [15:0] ir, pc;
        logic [31:0] ctrl;
        int          stallCnt;
        logic        wordOp;
        ir     = 16'($urandom);
        pc     = 16'($urandom);
        ctrl   = $urandom;
        wordOp = v.op inside {LDR, STR, LDI, STI};
        nextCycle();
        in_valid = 1'b1; in_op = v.op; in_addr = v.addr; in_wdata = v.wdata;
        in_alu = v.alu; in_ir = ir; in_pc = pc; in_ctrl = ctrl;
        stall_in = 1'b0; mem_resp = 1'b0;
        #1;
        chk($sformatf("v%0d accept mem_read", idx), mem_read, 0);
        stallCnt = stall_out ? 1 : 0;
        if (v.op != NONE) begin
            for (int k = 0; k <= v.lat; k++) begin
                nextCycle();
                mem_resp  = (k == v.lat);
                mem_rdata = v.rdata;
                #1;
                chk($sformatf("v%0d c%0d mem_read", idx, k), mem_read, !v.expWrite);
                chk($sformatf("v%0d c%0d mem_write", idx, k), mem_write, v.expWrite);
                if (wordOp) chk($sformatf("v%0d c%0d mem_addr", idx, k), mem_addr, v.expAddr);
                if (v.op != LDB) chk($sformatf("v%0d c%0d mem_wmask", idx, k), mem_wmask, v.expMask);
                if (v.expWrite) chk($sformatf("v%0d c%0d mem_wdata", idx, k), mem_wdata, v.expWdata);
                if (stall_out) stallCnt++;
            end
        end
        nextCycle();
        in_valid = 1'b0; mem_resp = 1'b0;
        #1;
        chk($sformatf("v%0d out_valid", idx), out_valid, 1);
        chk($sformatf("v%0d out_mdr", idx), out_mdr, v.expMdr);
        chk($sformatf("v%0d out_alu", idx), out_alu, v.alu);
        chk($sformatf("v%0d out_ir", idx), out_ir, ir);
        chk($sformatf("v%0d out_pc", idx), out_pc, pc);
        chk($sformatf("v%0d out_ctrl", idx), out_ctrl, ctrl);
        chk($sformatf("v%0d mem_read after", idx), mem_read, 0);
        chk($sformatf("v%0d stall cycles", idx), stallCnt, (v.op == NONE) ? 0 : v.lat + 1);
    endtask

    logic [15:0] refMem [32];
    logic [15:0] dutMem [32];

    // Reference: an instruction retires when upstream sees it taken
    // (in_valid, no downstream hold, no stall_out); outputs move only when
    // downstream is not held, and show exactly the instruction retired.
    task automatic randomRun(input int cycles);
        logic        prevTaken, prevStall, taken, eValid;
        logic [15:0] eMdr, eAlu, eIr, ePc, nMdr;
        logic [31:0] eCtrl;
        int          waitCnt, retired, idx, lane;
        prevTaken = 1'b0; prevStall = 1'b0; eValid = 1'b0;
        eMdr = '0; eAlu = '0; eIr = '0; ePc = '0; eCtrl = '0;
        waitCnt = -1; retired = 0;
        for (int i = 0; i < 32; i++) begin
            refMem[i] = 16'($urandom);
            dutMem[i] = refMem[i];
        end
        for (int c = 0; c < cycles; c++) begin
            nextCycle();
            if (!prevStall) begin
                eValid = prevTaken;
                if (prevTaken) begin
                    eMdr = nMdr; eAlu = in_alu; eIr = in_ir; ePc = in_pc; eCtrl = in_ctrl;
                end
            end
            chk("rnd out_valid", out_valid, eValid);
            if (eValid) begin
                chk("rnd out_mdr", out_mdr, eMdr);
                chk("rnd out_alu", out_alu, eAlu);
                chk("rnd out_ir/pc", {out_ir, out_pc}, {eIr, ePc});
                chk("rnd out_ctrl", out_ctrl, eCtrl);
            end
            if (prevTaken || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 4))
                    0: in_op = NONE;
                    1: in_op = LDR;
                    2: in_op = LDB;
                    3: in_op = STR;
                    default: in_op = STB;
                endcase
                in_addr = 16'($urandom_range(0, 63));
                in_wdata = 16'($urandom); in_alu = 16'($urandom);
                in_ir = 16'($urandom); in_pc = 16'($urandom); in_ctrl = $urandom;
            end
            stall_in = ($urandom_range(0, 3) == 0);
            if (mem_read || mem_write) begin
                if (waitCnt < 0) waitCnt = $urandom_range(0, 3);
                if (waitCnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = dutMem[mem_addr[5:1]];
                    waitCnt   = -1;
                end else begin
                    mem_resp  = 1'b0;
                    mem_rdata = 16'($urandom);
                    waitCnt--;
                end
            end else begin
                mem_resp  = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
            end
            chk("rnd read and write exclusive", mem_read && mem_write, 0);
            #1;
            taken = in_valid && !stall_in && !stall_out;
            if (mem_resp && mem_write) begin
                for (int b = 0; b < 2; b++)
                    if (mem_wmask[b]) dutMem[mem_addr[5:1]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
            if (taken) begin
                idx  = int'(in_addr[5:1]);
                lane = int'(in_addr[0]);
                nMdr = '0;
                case (in_op)
                    LDR: nMdr = refMem[idx];
                    LDB: nMdr = (refMem[idx] >> (8 * lane)) & 16'h00FF;
                    STR: refMem[idx] = in_wdata;
                    STB: refMem[idx][8*lane +: 8] = in_wdata[7:0];
                    default: nMdr = '0;
                endcase
                retired++;
            end
            prevTaken = taken;
            prevStall = stall_in;
        end
        chk("rnd enough retired", retired > 100, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_op = LDR; in_addr = 16'h0100;
        in_wdata = '0; in_alu = '0; in_ir = '0; in_pc = '0; in_ctrl = '0;
        stall_in = 1'b0; mem_rdata = '0; mem_resp = 1'b0;
        #2;
        chk("reset stall_out", stall_out, 0);
        nextCycle();
        nextCycle();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_mdr/alu", {out_mdr, out_alu}, 0);
        chk("reset out_ir/pc", {out_ir, out_pc}, 0);
        chk("reset out_ctrl", out_ctrl, 0);
        chk("reset mem_read/write", {mem_read, mem_write}, 0);
        chk("reset mem_wmask", mem_wmask, 0);
        chk("reset stall_out held", stall_out, 0);
        in_valid = 1'b0; in_op = NONE; rst_n = 1'b1;

        vecs.push_back(vec_t'{NONE, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0,
                              16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back(vec_t'{LDR, 16'h3001, 16'h0000, 16'h1111, 16'hBEEF, 3,
                              16'h3000, 2'b11, 16'h0000, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{STB, 16'h0041, 16'h00A5, 16'h2222, 16'hFFFF, 2,
                              16'h0040, 2'b10, 16'hA5A5, 1'b1, 16'h0000});
        vecs.push_back(vec_t'{LDB, 16'h0001, 16'h0000, 16'h3333, 16'h7F80, 1,
                              16'h0000, 2'b00, 16'h0000, 1'b0, 16'h007F});
        vecs.push_back(vec_t'{LDB, 16'h0010, 16'h0000, 16'h4444, 16'h7F80, 0,
                              16'h0010, 2'b00, 16'h0000, 1'b0, 16'h0080});
        vecs.push_back(vec_t'{STR, 16'h1235, 16'hCAFE, 16'h5555, 16'h1234, 1,
                              16'h1234, 2'b11, 16'hCAFE, 1'b1, 16'h0000});
        vecs.push_back(vec_t'{STB, 16'h0040, 16'h12C3, 16'h6666, 16'h0000, 0,
                              16'h0040, 2'b01, 16'hC3C3, 1'b1, 16'h0000});
`ifndef MEM_STAGE_INDIRECT_EN
        vecs.push_back(vec_t'{LDI, 16'h2001, 16'h0000, 16'h7777, 16'h5555, 1,
                              16'h2000, 2'b11, 16'h0000, 1'b0, 16'h5555});
        vecs.push_back(vec_t'{STI, 16'h0FFF, 16'h0BAD, 16'h8888, 16'h0000, 0,
                              16'h0FFE, 2'b11, 16'h0BAD, 1'b1, 16'h0000});
`endif
        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], i);

        // LDB whose response meets a downstream hold: result parks until release.
        nextCycle();
        in_valid = 1'b1; in_op = LDB; in_addr = 16'h0033; in_alu = 16'h0777;
        stall_in = 1'b0;
        nextCycle();
        mem_resp = 1'b1; mem_rdata = 16'h7F80; stall_in = 1'b1;
        #1;
        chk("hold resp mem_read", mem_read, 1);
        chk("hold resp stall_out", stall_out, 0);
        nextCycle();
        mem_resp = 1'b0;
        #1;
        chk("hold done out_valid", out_valid, 0);
        chk("hold done stall_out", stall_out, 1);
        chk("hold done mem_read", mem_read, 0);
        nextCycle();
        chk("hold done out_valid 2", out_valid, 0);
        stall_in = 1'b0;
        #1;
        chk("hold release stall_out", stall_out, 0);
        nextCycle();
        in_valid = 1'b0;
        #1;
        chk("hold release out_valid", out_valid, 1);
        chk("hold release out_mdr", out_mdr, 16'h007F);
        chk("hold release out_alu", out_alu, 16'h0777);

        // Reset during ACCESS, then a stale response.
        nextCycle();
        in_valid = 1'b1; in_op = LDR; in_addr = 16'h0100;
        nextCycle();
        chk("rst mid mem_read before", mem_read, 1);
        rst_n = 1'b0; in_valid = 1'b0;
        nextCycle();
        chk("rst mid mem_read", mem_read, 0);
        chk("rst mid out_valid", out_valid, 0);
        chk("rst mid stall_out", stall_out, 0);
        rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'hDEAD;
        nextCycle();
        mem_resp = 1'b0;
        #1;
        chk("late resp out_valid", out_valid, 0);
        chk("late resp mem_read", mem_read, 0);
        in_valid = 1'b1; in_op = NONE; in_alu = 16'h5A5A;
        #1;
        chk("post rst stall_out", stall_out, 0);
        nextCycle();
        in_valid = 1'b0;
        #1;
        chk("post rst out_valid", out_valid, 1);
        chk("post rst out_alu", out_alu, 16'h5A5A);

`ifdef MEM_STAGE_INDIRECT_EN
        nextCycle();
        in_valid = 1'b1; in_op = LDI; in_addr = 16'h2000; in_alu = 16'h0123;
        #1;
        chk("ldi accept stall_out", stall_out, 1);
        nextCycle();
        mem_resp = 1'b1; mem_rdata = 16'h4000;
        #1;
        chk("ldi read1", mem_read, 1);
        chk("ldi addr1", mem_addr, 16'h2000);
        chk("ldi stall1", stall_out, 1);
        nextCycle();
        mem_rdata = 16'h1111;
        #1;
        chk("ldi read2", mem_read, 1);
        chk("ldi addr2", mem_addr, 16'h4000);
        chk("ldi stall2", stall_out, 0);
        nextCycle();
        mem_resp = 1'b0; in_valid = 1'b0;
        #1;
        chk("ldi out_valid", out_valid, 1);
        chk("ldi out_mdr", out_mdr, 16'h1111);
`endif

        nextCycle();
        rst_n = 1'b0; in_valid = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        randomRun(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL declare parameter DATA_W, default 16, meaning data/address width in bits (multiple of 8, >= 16).
REQ-002 The block SHALL declare parameter CTRL_W, default 32, meaning width of the passthrough control word.
REQ-003 The block SHALL declare ports clk, input, 1, the single clock; rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL declare in_valid, input, 1, an upstream instruction is present.
REQ-005 The block SHALL declare in_op, input, mem_op_t, one of NONE, LDR, LDB, STR, STB, LDI, STI.
REQ-006 The block SHALL declare in_addr, in_wdata, in_alu, in_ir and in_pc, each input, DATA_W, holding effective address, store data, ALU result, IR and PC.
REQ-007 The block SHALL declare in_ctrl, input, CTRL_W, the control word.
REQ-008 The block SHALL declare stall_in, input, 1, a downstream hold.
REQ-009 The block SHALL declare stall_out, output, 1, telling upstream to hold its inputs stable.
REQ-010 The block SHALL declare the memory-side ports: mem_addr, output, DATA_W; mem_read and mem_write, output, 1 each; mem_wmask, output, DATA_W/8; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W; mem_resp, input, 1.
REQ-011 The block SHALL declare out_valid, output, 1, and out_mdr, out_alu, out_ir and out_pc, each output, DATA_W.
REQ-012 The block SHALL declare out_ctrl, output, CTRL_W.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS and DONE, plus IND when the indirect option is compiled in.
REQ-014 In IDLE with in_valid and in_op=NONE and stall_in low, the block SHALL load all out_* registers at the next edge, set out_mdr=0 and out_valid=1, giving 1-cycle latency.
REQ-015 In IDLE with in_valid, a memory op and stall_in low, the block SHALL drive stall_out=1 combinationally, register mem_addr, mem_wdata and mem_wmask, and enter ACCESS.
REQ-016 In ACCESS, the block SHALL hold mem_read (loads) or mem_write (stores) high with all memory outputs stable until mem_resp=1.
REQ-017 In ACCESS, stall_out SHALL equal !mem_resp.
REQ-018 On mem_resp with stall_in low, the block SHALL load the out_* registers, set out_valid=1 and return to IDLE.
REQ-019 On mem_resp with stall_in high, the block SHALL capture the result internally and enter DONE, keeping stall_out=1.
REQ-020 DONE SHALL transfer the captured result to the outputs on the first cycle stall_in is low, then go to IDLE.
REQ-021 When stall_in is high, the out_* registers SHALL hold their values.
REQ-022 When stall_in is low and no result is loaded, out_valid SHALL be 0.
REQ-023 Word ops SHALL clear address lane bits [log2(DATA_W/8)-1:0], set mem_wmask all ones and set out_mdr=mem_rdata.
REQ-024 Byte ops SHALL use lane L = the low address bits; LDB SHALL yield out_mdr = the zero-extended byte L; STB SHALL set mem_wmask = 1<<L and mem_wdata = in_wdata[7:0] replicated in all lanes.
REQ-025 For stores, out_mdr SHALL be 0.
REQ-026 mem_resp outside ACCESS and IND SHALL be ignored.
REQ-027 mem_read and mem_write SHALL never be high together.

Reset
REQ-028 With rst_n low at an edge, the block SHALL enter IDLE and clear out_valid, mem_read, mem_write, mem_wmask and all out_* data registers to 0.
REQ-029 A reset mid-ACCESS SHALL drop the memory request at that edge; a response arriving after reset SHALL be discarded.
REQ-030 stall_out SHALL be 0 while in reset.

Configuration
REQ-031 With MEM_STAGE_INDIRECT_EN defined, LDI/STI SHALL first read a word at in_addr (ACCESS), then use the aligned mem_rdata as the address of a second read (LDI) or write of in_wdata (STI) in IND, with stall_out=1 throughout and completion handled per REQ-018/019.
REQ-032 Without MEM_STAGE_INDIRECT_EN, the IND state SHALL be absent and LDI/STI SHALL behave as LDR/STR.

Structure
REQ-033 Package mem_stage_pkg SHALL hold mem_op_t, the state enum and the default DATA_W/CTRL_W constants.
REQ-034 The control-word type SHALL stay in the existing shared types package.
REQ-035 The block SHALL contain one sub-module, mem_byte_lane (combinational: address alignment, lane mask, write replication, load extraction), parameterised by DATA_W.

Verification
REQ-036 The bench SHALL check: NONE op with in_alu=0x1234 -> next cycle out_valid=1, out_alu=0x1234, out_mdr=0, no mem_read.
REQ-037 The bench SHALL check: LDR with addr=0x3001 and mem_resp after 3 cycles with rdata=0xBEEF -> mem_addr=0x3000, stall_out high 4 cycles, out_mdr=0xBEEF.
REQ-038 The bench SHALL check: STB with addr=0x0041 and wdata=0x00A5 -> mem_wmask=2'b10, mem_wdata=0xA5A5, mem_write held until mem_resp.
REQ-039 The bench SHALL check: LDB with addr odd and rdata=0x7F80 -> out_mdr=0x007F; mem_resp coincident with stall_in=1 -> DONE, outputs load only after stall_in falls.
REQ-040 The bench SHALL check: rst_n low during ACCESS, then a late mem_resp -> mem_read=0 after the edge, out_valid stays 0, FSM in IDLE.
REQ-041 The bench SHALL check, with MEM_STAGE_INDIRECT_EN: LDI at 0x2000 where mem[0x2000]=0x4000 and mem[0x4000]=0x1111 -> two reads, out_mdr=0x1111.
